midori_round_ctrl: RTL
======================

Name: midori_round_ctrl

Overview:
- Round sequencer for the round-based Midori64 datapath.
- Datapath = state register + shared SubCell layer (pipelined, SBOX_LAT stages) + ShuffleCell/MixColumn/KeyAdd.
- This block runs the block-level valid/ready handshakes, issues load/enable/last-round strobes and emits the round index for round-key and constant selection.
- One block in flight at a time; no datapath bits pass through this block.

Parameters:
ROUNDS, 16, total rounds incl. final SubCell+whitening round; legal 2..16
SBOX_LAT, 2, clock cycles per round spent in the shared S-box pipeline; legal 1..8

Ports:
clk  in  1  system clock, all flops rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid_i  in  1  plaintext shares valid at datapath input
in_ready_o  out  1  controller idle, can accept a block
out_valid_o  out  1  ciphertext shares valid in state register
out_ready_i  in  1  consumer accepts ciphertext
dp_load_o  out  1  load state reg with input XOR WK
dp_en_o  out  1  capture round result into state reg
dp_last_o  out  1  final round: bypass Shuffle/MixColumn, add WK instead of RK
round_o  out  4  current round index, drives RK/alpha mux
busy_o  out  1  high in RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, round=0, cnt=0. Outputs are in_ready_o=1, out_valid_o=0, dp_en_o=0, dp_last_o=0, round_o=0, busy_o=0. dp_load_o=0 unless in_valid_i.
- States: IDLE, RUN, DONE.
- in_ready_o = (state==IDLE). out_valid_o = (state==DONE). busy_o = (state==RUN).
- dp_load_o = in_valid_i & in_ready_o (combinational, same cycle as accept).
- IDLE:
  - in_valid_i=1 -> RUN next edge, round=0, cnt=0.
  - in_valid_i=0 -> stay.
- RUN:
  - cnt counts 0..SBOX_LAT-1. dp_en_o = (cnt==SBOX_LAT-1).
  - On dp_en_o: cnt->0.
    - round<ROUNDS-1: round++.
    - round==ROUNDS-1: go DONE.
  - dp_last_o = busy_o & (round==ROUNDS-1).
  - round_o = round. Width 4, never wraps within legal ROUNDS.
- DONE:
  - out_valid_o held until out_valid_o & out_ready_i.
  - On that edge: IDLE, round=0. New block accepted no earlier than the following cycle.
  - round_o holds ROUNDS-1 in DONE.
- Latency:
  - Accept edge to first out_valid_o cycle = ROUNDS*SBOX_LAT cycles.
  - Defaults: 32. Exactly ROUNDS dp_en_o pulses per block.
- Boundaries:
  - in_valid_i during RUN/DONE: ignored, no dp_load_o.
  - out_ready_i high before DONE: no effect.
  - out_ready_i held high at DONE entry: 1-cycle out_valid_o.
  - SBOX_LAT=1: dp_en_o high every RUN cycle.
  - rst_n asserted mid-RUN or DONE: immediate return to reset values, block discarded, no dp_en_o/out_valid_o afterwards.
  - Parameters outside legal range: elaboration error via generate-time check.

Optional Feature:
- Macro: MIDORI_CTRL_PRNG_EN. Defined: the block supplies fresh randomness for the TI S-box shares.
- Extra ports:
  - seed_i  in  32  LFSR seed.
  - rnd_o  out  32  fresh mask bits.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, reset value 32'h0000_0001.
  - On dp_load_o edge: load seed_i, or 32'h0000_0001 if seed_i==0.
  - Advances one step every RUN cycle; holds otherwise.
  - rnd_o = LFSR register.
- Not defined: seed_i/rnd_o and LFSR absent. All other behaviour identical, cycle-exact.

Test Plan:
- Reset then single block, defaults, out_ready_i=1: in_valid_i pulse at cycle 0 -> dp_load_o=1 cycle 0; dp_en_o at cycles 2,4,...,32 (16 pulses); dp_last_o only cycles 31-32; out_valid_o one cycle at 33; in_ready_o=1 at 34.
- Backpressure: out_ready_i=0 for 10 cycles after DONE -> out_valid_o held 10 cycles; round_o=15 stable; in_valid_i pulses meanwhile produce no dp_load_o.
- SBOX_LAT=1, ROUNDS=2: accept -> dp_en_o at cycles 1,2 with round_o 0,1; dp_last_o at cycle 2; out_valid_o at cycle 3.
- Reset mid-run: rst_n low at cycle 9 of RUN -> same-cycle busy_o=0, round_o=0, in_ready_o=1; no later dp_en_o until new accept.
- Back-to-back: in_valid_i held high continuously -> blocks accepted every ROUNDS*SBOX_LAT+2 cycles (34 at defaults); exactly one dp_load_o per block.
- MIDORI_CTRL_PRNG_EN, seed_i=0 -> rnd_o=32'h0000_0001 after load. seed_i=32'hDEADBEEF -> rnd_o after 1 RUN step equals the Galois shift of the seed; rnd_o frozen in DONE.

Source files
------------

// File: rtl/midori_round_ctrl.sv
// Round sequencer for the Midori64 round-based datapath: block handshakes,
// load/enable/last strobes and round index. Optional PRNG: MIDORI_CTRL_PRNG_EN.
module midori_round_ctrl #(
  parameter int unsigned ROUNDS   = 16,
  parameter int unsigned SBOX_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        dp_load_o,
  output logic        dp_en_o,
  output logic        dp_last_o,
  output logic [3:0]  round_o,
  output logic        busy_o
`ifdef MIDORI_CTRL_PRNG_EN
  ,
  input  logic [31:0] seed_i,
  output logic [31:0] rnd_o
`endif
);

  if (ROUNDS < 2 || ROUNDS > 16) begin : g_bad_rounds
    $error("midori_round_ctrl: ROUNDS must be in 2..16");
  end
  if (SBOX_LAT < 1 || SBOX_LAT > 8) begin : g_bad_lat
    $error("midori_round_ctrl: SBOX_LAT must be in 1..8");
  end

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [2:0] CNT_MAX  = 3'(SBOX_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [2:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q == S_RUN);
    dp_load_o   = in_valid_i & in_ready_o;
    dp_en_o     = busy_o & (cnt_q == CNT_MAX);
    dp_last_o   = busy_o & (round_q == LAST_RND);
    round_o     = round_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = S_RUN;
          round_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (dp_en_o) begin
          cnt_d = '0;
          if (round_q == LAST_RND) state_d = S_DONE;
          else                     round_d = round_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef MIDORI_CTRL_PRNG_EN
  // Galois LFSR, x^32+x^22+x^2+x+1, shifting towards the MSB.
  localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

  logic [31:0] lfsr_q, lfsr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 32'h0000_0001;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (dp_load_o) begin
      lfsr_d = (seed_i == '0) ? 32'h0000_0001 : seed_i;
    end else if (busy_o) begin
      lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_TAPS : '0);
    end
  end

  assign rnd_o = lfsr_q;
`endif

endmodule
